// File: rtl/md_iter_unit.sv
// Iterative 32-cycle multiply/divide unit for the EXE stage: shift-add multiply,
// restoring divide, sign fix-up, then a one-cycle HI/LO write strobe.
module md_iter_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            cancel,
  output logic            MDPause,
  output logic            multbusy,
  output logic            divbusy,
  output logic            multover,
  output logic            divover,
  output logic            mdcs,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = 6;
  localparam logic [CW-1:0]   LAST    = CW'(ITER - 1);
  localparam logic [CW-1:0]   CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] ONE     = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] ONE2  = {{(2*XLEN-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic [XLEN-1:0]   a_q, a_d, ma_q, ma_d, mb_q, mb_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              multbusy_q, multbusy_d, divbusy_q, divbusy_d;
  logic              multover_q, multover_d, divover_q, divover_d;

  logic [XLEN:0]     msum_s, rem_sh_s, rem_sub_s;
  logic              rem_ge_s, neg_a_s, neg_b_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_s, rem_s;

  // Mult keeps the partial product in acc high and shifts it right into acc low;
  // div keeps the remainder in acc high and shifts quotient bits into acc low.
  assign msum_s    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (mb_q[0] ? {1'b0, ma_q} : {(XLEN+1){1'b0}});
  assign rem_sh_s  = {acc_q[2*XLEN-1:XLEN], ma_q[XLEN-1]};
  assign rem_ge_s  = (rem_sh_s >= {1'b0, mb_q});
  assign rem_sub_s = rem_sh_s - {1'b0, mb_q};
  assign prod_s    = (sa_q ^ sb_q) ? (~acc_q + ONE2) : acc_q;
  assign quot_s    = (sa_q ^ sb_q) ? (~acc_q[XLEN-1:0] + ONE) : acc_q[XLEN-1:0];
  assign rem_s     = sa_q ? (~acc_q[2*XLEN-1:XLEN] + ONE) : acc_q[2*XLEN-1:XLEN];
  assign neg_a_s   = !op[0] && a[XLEN-1];
  assign neg_b_s   = !op[0] && b[XLEN-1];

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    a_d     = a_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          state_d = S_CALC;
          op_d    = op;
          sa_d    = neg_a_s;
          sb_d    = neg_b_s;
          a_d     = a;
          ma_d    = neg_a_s ? (~a + ONE) : a;
          mb_d    = neg_b_s ? (~b + ONE) : b;
          acc_d   = {(2*XLEN){1'b0}};
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (op_q[1]) begin
            acc_d = {(rem_ge_s ? rem_sub_s[XLEN-1:0] : rem_sh_s[XLEN-1:0]),
                     acc_q[XLEN-2:0], rem_ge_s};
            ma_d  = {ma_q[XLEN-2:0], 1'b0};
          end else begin
            acc_d = {msum_s, acc_q[XLEN-1:1]};
            mb_d  = {1'b0, mb_q[XLEN-1:1]};
          end
          if (cnt_q == LAST) begin
            state_d = S_FIX;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_FIX: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
          if (!op_q[1]) begin
            {hi_d, lo_d} = prod_s;
          end else if (mb_q == {XLEN{1'b0}}) begin
            lo_d = {XLEN{1'b1}};
            hi_d = a_q;
          end else begin
            lo_d = quot_s;
            hi_d = rem_s;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status flags registered from the next state so they align with it
  always_comb begin
    multbusy_d = ((state_d == S_CALC) || (state_d == S_FIX)) && !op_d[1];
    divbusy_d  = ((state_d == S_CALC) || (state_d == S_FIX)) && op_d[1];
    multover_d = (state_q == S_FIX) && !cancel && !op_q[1];
    divover_d  = (state_q == S_FIX) && !cancel && op_q[1];
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= S_IDLE;
      cnt_q      <= {CW{1'b0}};
      op_q       <= 2'b00;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      a_q        <= {XLEN{1'b0}};
      ma_q       <= {XLEN{1'b0}};
      mb_q       <= {XLEN{1'b0}};
      acc_q      <= {(2*XLEN){1'b0}};
      hi_q       <= {XLEN{1'b0}};
      lo_q       <= {XLEN{1'b0}};
      multbusy_q <= 1'b0;
      divbusy_q  <= 1'b0;
      multover_q <= 1'b0;
      divover_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      a_q        <= a_d;
      ma_q       <= ma_d;
      mb_q       <= mb_d;
      acc_q      <= acc_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      multbusy_q <= multbusy_d;
      divbusy_q  <= divbusy_d;
      multover_q <= multover_d;
      divover_q  <= divover_d;
    end
  end

  // The stall covers the issue cycle itself, hence the unregistered IDLE term.
  assign MDPause  = ((state_q == S_IDLE) && start && !cancel) ||
                    (state_q == S_CALC) || (state_q == S_FIX);
  assign multbusy = multbusy_q;
  assign divbusy  = divbusy_q;
  assign multover = multover_q;
  assign divover  = divover_q;
  assign mdcs     = multover_q | divover_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_md_iter_unit.sv
// Randomised scoreboard bench for md_iter_unit: an arithmetic reference model
// predicts HI/LO and the cycle each result appears; a negedge monitor compares.
module tb_md_iter_unit;

  logic        clk = 1'b0;
  logic        clr, start, cancel;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        MDPause, multbusy, divbusy, multover, divover, mdcs;
  logic [31:0] hi, lo;

  md_iter_unit #(.XLEN(32), .ITER(32)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
    .MDPause(MDPause), .multbusy(multbusy), .divbusy(divbusy),
    .multover(multover), .divover(divover), .mdcs(mdcs), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    bit          is_div;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sbq[$];
  int          cyc = 0;
  int          idle_from = 0;
  int          act_lo = 1;
  int          act_hi = 0;
  bit          act_div = 1'b0;
  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;
  int          n_checks = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endfunction

  function automatic void ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] h, output logic [31:0] l);
    logic signed [63:0] sx, sy, q, r;
    logic [63:0] p;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    case (o)
      2'b00: begin p = sx * sy; h = p[63:32]; l = p[31:0]; end
      2'b01: begin p = {32'd0, x} * {32'd0, y}; h = p[63:32]; l = p[31:0]; end
      default: begin
        if (y == 32'd0) begin
          l = 32'hFFFF_FFFF; h = x;
        end else if (o == 2'b10) begin
          q = sx / sy; r = sx % sy; l = q[31:0]; h = r[31:0];
        end else begin
          l = x / y; h = x % y;
        end
      end
    endcase
  endfunction

  // Monitor: pops the scoreboard on the predicted result cycle, otherwise expects quiet outputs
  logic        in_win, exp_pause;
  exp_t        got;
  always @(negedge clk) begin
    if (!clr) begin
      in_win    = (cyc >= act_lo) && (cyc <= act_hi);
      exp_pause = in_win || ((cyc >= idle_from) && start && !cancel);
      chk("MDPause", 32'(MDPause), 32'(exp_pause));
      chk("multbusy", 32'(multbusy), 32'(in_win && !act_div));
      chk("divbusy", 32'(divbusy), 32'(in_win && act_div));
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        got = sbq.pop_front();
        last_hi = got.hi;
        last_lo = got.lo;
        chk("mdcs", 32'(mdcs), 32'd1);
        chk("multover", 32'(multover), 32'(!got.is_div));
        chk("divover", 32'(divover), 32'(got.is_div));
      end else begin
        chk("mdcs_quiet", 32'(mdcs), 32'd0);
        chk("over_quiet", {30'd0, multover, divover}, 32'd0);
      end
      chk("hi", hi, last_hi);
      chk("lo", lo, last_lo);
    end
  end

  // Advance one clock and update the model with what the DUT sampled at that edge
  task automatic step();
    int          c0;
    bit          acc, canc;
    logic [1:0]  o;
    logic [31:0] x, y, h, l;
    exp_t        e;
    c0   = cyc;
    acc  = (c0 >= idle_from) && start && !cancel && !clr;
    canc = cancel && !clr && (c0 >= act_lo) && (c0 <= act_hi);
    o = op; x = a; y = b;
    @(posedge clk); #2;
    if (acc) begin
      ref_model(o, x, y, h, l);
      e.due = cyc + 33; e.is_div = o[1]; e.hi = h; e.lo = l;
      sbq.push_back(e);
      act_lo = cyc; act_hi = cyc + 32; act_div = o[1];
      idle_from = cyc + 34;
    end else if (canc) begin
      act_hi = c0;
      idle_from = c0 + 1;
      void'(sbq.pop_back());
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (cyc < idle_from && guard < 200) begin
      step();
      guard++;
    end
    if (guard >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL wait_idle timeout at cycle %0d", cyc);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    wait_idle();
    start = 1'b1; op = o; a = x; b = y;
    step();
    start = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1; start = 1'b0; cancel = 1'b0;
    sbq.delete();
    act_lo = 1; act_hi = 0; idle_from = 0;
    last_hi = 32'd0; last_lo = 32'd0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    clr = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    clr = 1'b1; start = 1'b0; cancel = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clk);
    #2; clr = 1'b0;
    step(); step();

    issue(2'b00, 32'hFFFF_FFFD, 32'h0000_0007);
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
    issue(2'b11, 32'h0000_0007, 32'h0000_0002);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(2'b11, 32'h1234_5678, 32'h0000_0000);
    issue(2'b10, 32'h0000_0000, 32'h0000_0005);
    issue(2'b10, 32'h8765_4321, 32'h0000_0000);

    // Cancel at CALC cycle 10, then a DIV interrupted by reset at CALC cycle 5
    issue(2'b00, 32'h0000_1234, 32'h0000_5678);
    repeat (10) step();
    cancel = 1'b1; step(); cancel = 1'b0;
    repeat (3) step();
    issue(2'b10, 32'h0000_0064, 32'h0000_0007);
    repeat (5) step();
    do_clr();
    repeat (3) step();

    // Cancel in FIX, cancel in DONE, and cancel together with start in IDLE
    issue(2'b01, 32'hDEAD_BEEF, 32'h0000_0003);
    repeat (32) step();
    cancel = 1'b1; step(); cancel = 1'b0;
    issue(2'b11, 32'hDEAD_BEEF, 32'h0000_0010);
    repeat (33) step();
    cancel = 1'b1; step(); cancel = 1'b0;
    wait_idle();
    start = 1'b1; cancel = 1'b1; op = 2'b00; a = 32'd5; b = 32'd6;
    step();
    start = 1'b0; cancel = 1'b0;
    step();

    // Random operations with occasional cancels
    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom_range(0, 3)), pick(), pick());
      if ($urandom_range(0, 5) == 0) begin
        repeat ($urandom_range(0, 33)) step();
        cancel = 1'b1; step(); cancel = 1'b0;
      end
    end

    // start held high with changing operands: only IDLE cycles may sample it
    wait_idle();
    start = 1'b1;
    for (int i = 0; i < 120; i++) begin
      op = 2'($urandom_range(0, 3)); a = pick(); b = pick();
      step();
    end
    start = 1'b0;
    repeat (40) step();

    if (sbq.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_drain: %0d results never appeared", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
